uart_tx_arbiter: RTL

//  Multi-source UART TX front end sitting between the RX/TX FIFOs and the monitor/CPU IO writers.

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_lb_fifo.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants and helpers for the UART TX arbiter
package uart_tx_arbiter_pkg;

  localparam int UART_DW    = 8;
  localparam int ERR_W      = 3;
  localparam int ERR_RX_OVR = 0;
  localparam int ERR_RX_UNR = 1;
  localparam int ERR_TX_OVR = 2;

  // Requester index k places after base, wrapping over n requesters.
  function automatic int rr_next(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/uart_lb_fifo.sv
// rtl/uart_lb_fifo.sv - small synchronous FIFO buffering RX->TX echo characters
module uart_lb_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_wdata,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_level   = r_cnt;
  assign o_rdata   = r_mem[r_rp];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= i_wdata;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin merge of writer channels and RX echo onto the TX FIFO
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DW       = UART_DW,
  parameter int NSRC     = 2,
  parameter int LB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lb_en,
  output logic                        rx_rden,
  input  logic [DW-1:0]               rx_rdata,
  input  logic                        rx_fifo_dvalid,
  input  logic                        rx_fifo_overrun,
  input  logic                        rx_fifo_underrun,
  output logic [DW-1:0]               rout,
  output logic                        rout_en,
  input  logic [NSRC*DW-1:0]          src_data,
  input  logic [NSRC-1:0]             src_valid,
  output logic [NSRC-1:0]             src_ready,
  output logic [DW-1:0]               tx_wdata,
  output logic                        tx_wten,
  input  logic                        tx_fifo_full,
  input  logic                        tx_fifo_overrun,
  input  logic                        err_clr,
  output logic [ERR_W-1:0]            err_flags,
  output logic [$clog2(LB_DEPTH):0]   lb_level
);

  localparam int NREQ = NSRC + 1;
  localparam int PW   = $clog2(NREQ);

  logic [PW-1:0]    r_rr;
  logic [DW-1:0]    r_rout;
  logic             r_rout_en;
  logic [ERR_W-1:0] r_err;

  logic             w_lb_full;
  logic             w_lb_empty;
  logic             w_lb_push;
  logic             w_lb_pop;
  logic [DW-1:0]    w_lb_rdata;
  logic [NREQ-1:0]  w_req;
  logic             w_gnt_found;
  logic [PW-1:0]    w_gnt_idx;
  logic [DW-1:0]    w_gnt_data;
  logic             w_wr;
  logic [ERR_W-1:0] w_err_set;

  // RX is only back-pressured when its char would have to go into a full echo buffer.
  assign rx_rden   = rx_fifo_dvalid & (~lb_en | ~w_lb_full);
  assign w_lb_push = rx_rden & lb_en;
  assign w_req     = {~w_lb_empty, src_valid};

  uart_lb_fifo #(
    .DW    (DW),
    .DEPTH (LB_DEPTH)
  ) u_lb_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_lb_push),
    .i_wdata (rx_rdata),
    .i_pop   (w_lb_pop),
    .o_rdata (w_lb_rdata),
    .o_full  (w_lb_full),
    .o_empty (w_lb_empty),
    .o_level (lb_level)
  );

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = r_rr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt_found && w_req[rr_next(int'(r_rr), k, NREQ)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = PW'(rr_next(int'(r_rr), k, NREQ));
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    if (w_gnt_found) begin
      if (w_gnt_idx == PW'(NSRC)) begin
        w_gnt_data = w_lb_rdata;
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (w_gnt_idx == PW'(i)) w_gnt_data = src_data[i*DW +: DW];
        end
      end
    end
  end

  assign w_wr     = w_gnt_found & ~tx_fifo_full;
  assign tx_wten  = w_wr;
  assign tx_wdata = w_gnt_data;
  assign w_lb_pop = w_wr & (w_gnt_idx == PW'(NSRC));

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = w_wr & (w_gnt_idx == PW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= PW'(NSRC);
    end else if (w_wr) begin
      r_rr <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rout    <= '0;
      r_rout_en <= 1'b0;
    end else begin
      r_rout_en <= rx_rden;
      if (rx_rden) r_rout <= rx_rdata;
    end
  end

  assign rout    = r_rout;
  assign rout_en = r_rout_en;

  always_comb begin
    w_err_set             = '0;
    w_err_set[ERR_RX_OVR] = rx_fifo_overrun;
    w_err_set[ERR_RX_UNR] = rx_fifo_underrun;
    w_err_set[ERR_TX_OVR] = tx_fifo_overrun;
  end

  // A fault pulse coinciding with a clear still leaves its bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= (r_err & ~{ERR_W{err_clr}}) | w_err_set;
    end
  end

  assign err_flags = r_err;

endmodule
